// File: rtl/hamming_minmax_engine_if.sv
// hamming_minmax_engine_if: start/Done handshake, data-memory bus and result outputs
interface hamming_minmax_engine_if;
    logic       start;
    logic       Done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [4:0] min_dist;
    logic [4:0] max_dist;
    logic [4:0] min_j;
    logic [4:0] min_k;
    logic [4:0] max_j;
    logic [4:0] max_k;

    modport slave (
        input  start, mem_rd_data,
        output Done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output min_dist, max_dist, min_j, min_k, max_j, max_k
    );

    modport master (
        output start, mem_rd_data,
        input  Done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  min_dist, max_dist, min_j, min_k, max_j, max_k
    );
endinterface

// File: rtl/hamming_minmax_engine.sv
// hamming_minmax_engine: min/max pairwise Hamming distance over operands loaded from data memory
module hamming_minmax_engine #(
    parameter int N_OPS    = 32,
    parameter int RES_ADDR = 64
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    hamming_minmax_engine_if.slave  bus
);
    localparam int          LW    = $clog2(2 * N_OPS);
    localparam int          CW    = $clog2(2 * N_OPS + 1);
    localparam logic [CW-1:0] LEND = CW'(2 * N_OPS);
    localparam logic [4:0]  JL    = 5'(N_OPS - 2);
    localparam logic [4:0]  KL    = 5'(N_OPS - 1);
    localparam logic [7:0]  RA0   = 8'(RES_ADDR);
    localparam logic [7:0]  RA1   = 8'(RES_ADDR + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CMP, WR_MIN, WR_MAX, DONE} state_t;

    state_t        r_state;
    logic          r_start_q;
    logic          r_done;
    logic          r_rd_en;
    logic          r_wr_en;
    logic [7:0]    r_addr;
    logic [7:0]    r_wr_data;
    logic          r_lv;
    logic [LW-1:0] r_la;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_j;
    logic [4:0]    r_k;
    logic [4:0]    r_min;
    logic [4:0]    r_max;
    logic [4:0]    r_min_j;
    logic [4:0]    r_min_k;
    logic [4:0]    r_max_j;
    logic [4:0]    r_max_k;
    logic [15:0]   r_op [N_OPS];

    logic [15:0]   w_x;
    logic [4:0]    w_dist;
    logic          w_lt;
    logic          w_gt;
    logic          w_last;

    // distance of the pair currently addressed by the scan counters
    always_comb begin
        w_x    = r_op[r_j] ^ r_op[r_k];
        w_dist = '0;
        for (int i = 0; i < 16; i++) w_dist = w_dist + 5'(w_x[i]);
        w_lt   = w_dist < r_min;
        w_gt   = w_dist > r_max;
        w_last = (r_j == JL) && (r_k == KL);
    end

    // returned bytes land in the operand half chosen by the address issued one cycle earlier
    always_ff @(posedge Clk) begin
        if (r_lv && r_la[0]) r_op[r_la[LW-1:1]][7:0] <= bus.mem_rd_data;
        if (r_lv && !r_la[0]) r_op[r_la[LW-1:1]][15:8] <= bus.mem_rd_data;
    end

    // control FSM with registered bus and result outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_lv      <= 1'b0;
            r_la      <= '0;
            r_cnt     <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_min     <= 5'd16;
            r_max     <= '0;
            r_min_j   <= '0;
            r_min_k   <= '0;
            r_max_j   <= '0;
            r_max_k   <= '0;
        end else begin
            r_start_q <= bus.start;
            r_lv      <= r_rd_en;
            r_la      <= r_addr[LW-1:0];
            case (r_state)
                IDLE: begin
                    if (r_start_q && !bus.start) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_j     <= '0;
                        r_k     <= 5'd1;
                        r_min   <= 5'd16;
                        r_max   <= '0;
                        r_min_j <= '0;
                        r_min_k <= '0;
                        r_max_j <= '0;
                        r_max_k <= '0;
                    end
                end
                LOAD: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_rd_en <= r_cnt < LEND - 1'b1;
                    r_addr  <= r_cnt < LEND - 1'b1 ? r_addr + 8'd1 : 8'd0;
                    if (r_cnt == LEND) r_state <= CMP;
                end
                CMP: begin
                    if (w_lt) begin
                        r_min   <= w_dist;
                        r_min_j <= r_j;
                        r_min_k <= r_k;
                    end
                    if (w_gt) begin
                        r_max   <= w_dist;
                        r_max_j <= r_j;
                        r_max_k <= r_k;
                    end
                    if (w_last) begin
                        r_state   <= WR_MIN;
                        r_wr_en   <= 1'b1;
                        r_addr    <= RA0;
                        r_wr_data <= {3'b0, w_lt ? w_dist : r_min};
                    end else begin
                        r_j <= r_k == KL ? r_j + 5'd1 : r_j;
                        r_k <= r_k == KL ? r_j + 5'd2 : r_k + 5'd1;
                    end
                end
                WR_MIN: begin
                    r_state   <= WR_MAX;
                    r_addr    <= RA1;
                    r_wr_data <= {3'b0, r_max};
                end
                WR_MAX: begin
                    r_state   <= DONE;
                    r_wr_en   <= 1'b0;
                    r_addr    <= '0;
                    r_wr_data <= '0;
                    r_done    <= 1'b1;
                end
                DONE: begin
                    if (bus.start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Done        = r_done;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_rd_en   = r_rd_en;
    assign bus.mem_wr_en   = r_wr_en;
    assign bus.mem_wr_data = r_wr_data;
    assign bus.min_dist    = r_min;
    assign bus.max_dist    = r_max;
    assign bus.min_j       = r_min_j;
    assign bus.min_k       = r_min_k;
    assign bus.max_j       = r_max_j;
    assign bus.max_k       = r_max_k;
endmodule

// File: tb/tb_hamming_minmax_engine.sv
// tb_hamming_minmax_engine: randomized and directed checks against a pairwise-scan reference model
module tb_hamming_minmax_engine;
    logic       Clk;
    logic       Reset_n;
    logic [7:0] mem [256];
    logic [15:0] wlog [$];
    int         checks;
    int         errors;

    hamming_minmax_engine_if bus();

    hamming_minmax_engine dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // data memory: one-cycle read latency, writes recorded in a log
    always @(posedge Clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_en) wlog.push_back({bus.mem_addr, bus.mem_wr_data});
    end

    task automatic ref_model(output logic [4:0] mn, output logic [4:0] mx,
                             output logic [4:0] mnj, output logic [4:0] mnk,
                             output logic [4:0] mxj, output logic [4:0] mxk);
        logic [15:0] a;
        logic [15:0] b;
        int d;
        mn = 16; mx = 0; mnj = 0; mnk = 0; mxj = 0; mxk = 0;
        for (int j = 0; j < 32; j++)
            for (int k = j + 1; k < 32; k++) begin
                a = {mem[2*j], mem[2*j+1]};
                b = {mem[2*k], mem[2*k+1]};
                d = $countones(a ^ b);
                if (d < int'(mn)) begin mn = 5'(d); mnj = 5'(j); mnk = 5'(k); end
                if (d > int'(mx)) begin mx = 5'(d); mxj = 5'(j); mxk = 5'(k); end
            end
    endtask

    task automatic do_run(input int stop_at, input int tog_at, output int edges);
        @(negedge Clk);
        bus.start = 1'b1;
        repeat (3) @(negedge Clk);
        bus.start = 1'b0;
        @(posedge Clk);
        edges = 0;
        while (edges < stop_at) begin
            @(posedge Clk);
            edges++;
            #1;
            if (tog_at > 0 && edges == tog_at) bus.start = 1'b1;
            if (tog_at > 0 && edges == tog_at + 10) bus.start = 1'b0;
            if (bus.Done) break;
        end
    endtask

    task automatic test_reset();
        int bad;
        Reset_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({bus.Done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_bus: got done=%b rd=%b wr=%b addr=%0d wd=%0d, expected all 0",
                     bus.Done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data);
        end
        checks++;
        if ({bus.min_dist, bus.max_dist, bus.min_j, bus.min_k, bus.max_j, bus.max_k} !== {5'd16, 25'd0}) begin
            errors++;
            $display("FAIL reset_results: got min=%0d max=%0d idx=%0d,%0d,%0d,%0d, expected 16 0 0,0,0,0",
                     bus.min_dist, bus.max_dist, bus.min_j, bus.min_k, bus.max_j, bus.max_k);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge Clk);
            if (bus.mem_rd_en !== 1'b0 || bus.Done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL low_start_no_launch: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_zeros();
        int e;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        n = wlog.size();
        do_run(700, 0, e);
        checks++;
        if (e != 563) begin errors++; $display("FAIL zeros_latency: got %0d edges, expected 563", e); end
        checks++;
        if (wlog.size() != n + 2 || wlog[n] !== {8'd64, 8'd0} || wlog[n+1] !== {8'd65, 8'd0}) begin
            errors++;
            $display("FAIL zeros_writes: got %0d writes, expected 2 (64<=0, 65<=0)", wlog.size() - n);
        end
        checks++;
        if ({bus.min_j, bus.min_k, bus.max_dist} !== {5'd0, 5'd1, 5'd0}) begin
            errors++;
            $display("FAIL zeros_pair: got min (%0d,%0d) max %0d, expected (0,1) 0", bus.min_j, bus.min_k, bus.max_dist);
        end
    endtask

    task automatic test_alternating();
        int e;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = (i % 4 < 2) ? 8'h00 : 8'hFF;
        n = wlog.size();
        do_run(700, 0, e);
        checks++;
        if (e != 563) begin errors++; $display("FAIL alt_latency: got %0d edges, expected 563", e); end
        checks++;
        if (wlog.size() != n + 2 || wlog[n] !== {8'd64, 8'd0} || wlog[n+1] !== {8'd65, 8'd16}) begin
            errors++;
            $display("FAIL alt_writes: got %0d writes, expected 2 (64<=0, 65<=16)", wlog.size() - n);
        end
        checks++;
        if ({bus.min_dist, bus.min_j, bus.min_k, bus.max_dist, bus.max_j, bus.max_k} !==
            {5'd0, 5'd0, 5'd2, 5'd16, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL alt_pairs: got min %0d (%0d,%0d) max %0d (%0d,%0d), expected 0 (0,2) 16 (0,1)",
                     bus.min_dist, bus.min_j, bus.min_k, bus.max_dist, bus.max_j, bus.max_k);
        end
    endtask

    task automatic test_random(input int tog_at);
        int e;
        int n;
        logic [4:0] mn, mx, mnj, mnk, mxj, mxk;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        ref_model(mn, mx, mnj, mnk, mxj, mxk);
        n = wlog.size();
        do_run(700, tog_at, e);
        checks++;
        if (e != 563) begin errors++; $display("FAIL rand_latency(tog=%0d): got %0d edges, expected 563", tog_at, e); end
        checks++;
        if (wlog.size() != n + 2 || wlog[n] !== {8'd64, 3'b0, mn} || wlog[n+1] !== {8'd65, 3'b0, mx}) begin
            errors++;
            $display("FAIL rand_writes(tog=%0d): got %0d writes, expected 2 (64<=%0d, 65<=%0d)",
                     tog_at, wlog.size() - n, mn, mx);
        end
        checks++;
        if ({bus.min_dist, bus.min_j, bus.min_k, bus.max_dist, bus.max_j, bus.max_k} !==
            {mn, mnj, mnk, mx, mxj, mxk}) begin
            errors++;
            $display("FAIL rand_pairs(tog=%0d): got min %0d (%0d,%0d) max %0d (%0d,%0d), expected min %0d (%0d,%0d) max %0d (%0d,%0d)",
                     tog_at, bus.min_dist, bus.min_j, bus.min_k, bus.max_dist, bus.max_j, bus.max_k,
                     mn, mnj, mnk, mx, mxj, mxk);
        end
    endtask

    task automatic test_reset_mid_run();
        int e;
        int n;
        mem[64] = 8'd0;
        mem[65] = 8'd64;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        n = wlog.size();
        do_run(300, 0, e);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.Done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.min_dist, bus.max_dist, bus.min_j, bus.max_k} !==
            {3'd0, 8'd0, 5'd16, 5'd0, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: got done=%b rd=%b addr=%0d min=%0d max=%0d, expected 0 0 0 16 0",
                     bus.Done, bus.mem_rd_en, bus.mem_addr, bus.min_dist, bus.max_dist);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        checks++;
        if (wlog.size() != n || mem[64] !== 8'd0 || mem[65] !== 8'd64) begin
            errors++;
            $display("FAIL midreset_nowrite: got %0d writes, expected 0 with mem64/65 = 0/64", wlog.size() - n);
        end
        test_random(0);
    endtask

    task automatic test_hold_done();
        int bad;
        bad = 0;
        repeat (50) begin
            @(negedge Clk);
            if (bus.Done !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL done_hold: Done low on %0d cycles, expected 0", bad); end
        @(negedge Clk);
        bus.start = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_release: got %b, expected 0", bus.Done); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        test_reset();
        test_zeros();
        test_alternating();
        repeat (3) test_random(0);
        test_random(200);
        test_reset_mid_run();
        test_hold_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
